// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Holds the FIFO entry type (pc + instruction word) and the word-alignment helper.
package fetch_pkg;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned ROM_LATENCY = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch unit and its neighbours.
//   rom_enable/rom_address : read request to the instruction ROM
//   rom_data               : ROM read data, one cycle after the request
//   redirect_valid/pc      : branch/exception redirect from execute
//   instr_valid/ready/data/pc : instruction handshake towards decode
// master = fetch unit side, slave = ROM/execute/decode side.
interface instruction_fetch_if;

  logic        rom_enable;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  modport master (
    output rom_enable, rom_address, instr_valid, instr_data, instr_pc,
    input  rom_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  rom_enable, rom_address, instr_valid, instr_data, instr_pc,
    output rom_data, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_push      : write i_entry (accepted when not full, or full with a pop)
//   i_pop       : consume the head entry (ignored when empty)
//   i_flush     : empty the FIFO; wins over push and pop
//   o_count     : number of stored entries
//   o_valid     : head entry is valid
//   o_head      : head entry (read straight out of the storage registers)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_entry,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_valid,
  output fetch_entry_t             o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  // Qualify pop/push against the current occupancy.
  always_comb begin
    w_pop  = i_pop & (r_count != '0);
    w_push = i_push & ((r_count != L_DEPTH) | w_pop);
  end

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues word reads to a ROM with
// one cycle of read latency, buffers returned words with their PC and hands
// them to decode over valid/ready. A redirect flushes buffered and in-flight
// fetches and restarts fetching at the (word-aligned) target.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : instruction_fetch_if.master (ROM port, redirect, decode port)
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] L_DEPTH = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic          r_drop;
  logic          w_pop;
  logic          w_issue;
  logic          w_push;
  logic [CW:0]   w_credit;
  logic [CW-1:0] w_count;
  logic          w_head_valid;
  fetch_entry_t  w_head;
  fetch_entry_t  w_entry;

  // Issue credit: only request a word if the FIFO is sure to have room for it.
  // Issue is held off while reset is asserted so rom_enable drops immediately.
  always_comb begin
    w_pop         = w_head_valid & bus.instr_ready;
    w_credit      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    w_push        = r_inflight & ~r_drop;
    w_entry.pc    = r_fetch_pc - 32'(WORD_BYTES);
    w_entry.instr = bus.rom_data;
    if (!rst_n || bus.redirect_valid) begin
      w_issue = 1'b0;
    end else begin
      w_issue = (w_credit < L_DEPTH);
    end
  end

  // Fetch PC, in-flight flag and response-kill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        r_fetch_pc <= align_word(bus.redirect_pc);
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
      end
      r_inflight <= w_issue;
      r_drop     <= bus.redirect_valid & r_inflight;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_count (w_count),
    .o_valid (w_head_valid),
    .o_head  (w_head)
  );

  assign bus.rom_enable  = w_issue;
  assign bus.rom_address = r_fetch_pc;
  assign bus.instr_valid = w_head_valid;
  assign bus.instr_data  = w_head.instr;
  assign bus.instr_pc    = w_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. The reference model views the
// unit as "deliver the word stream pc, pc+4, ... starting at the last redirect
// target (or reset PC), never delivering anything from before a redirect".
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instruction_fetch_if bus_if ();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  int since_redir = 3;
  int d0;

  logic [31:0] exp_pc, exp_fetch, pend_addr, prev_pc, prev_data;
  logic        pend, prev_hold;
  logic        s_en, s_valid;
  logic [31:0] s_addr, s_pc, s_data;
  logic [31:0] wrap_seq [3];

  // ROM contents: a fixed scramble of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[7:0] ^ 8'h5A, a[31:24], ~a[15:8], a[23:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One clock cycle: ROM answers last cycle's request, inputs applied,
  // outputs sampled mid-cycle and compared against the stream model.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    bus_if.rom_data       = pend ? rom_word(pend_addr) : $urandom();
    bus_if.instr_ready    = rdy;
    bus_if.redirect_valid = rv;
    bus_if.redirect_pc    = rpc;
    #1;
    s_en    = bus_if.rom_enable;
    s_addr  = bus_if.rom_address;
    s_valid = bus_if.instr_valid;
    s_pc    = bus_if.instr_pc;
    s_data  = bus_if.instr_data;
    if (since_redir < 3) since_redir++;
    if (since_redir < 3) check1("gap_after_redirect", s_valid, 1'b0);
    check("rom_address", s_addr, exp_fetch);
    if (rv) check1("no_issue_on_redirect", s_en, 1'b0);
    else if (s_en) exp_fetch = exp_fetch + 32'd4;
    if (prev_hold) begin
      check1("hold_valid", s_valid, 1'b1);
      check("hold_pc", s_pc, prev_pc);
      check("hold_data", s_data, prev_data);
    end
    if (s_valid && rdy && !rv) begin
      check("pop_pc", s_pc, exp_pc);
      check("pop_data", s_data, rom_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (rv) begin
      exp_pc      = rpc & 32'hFFFF_FFFC;
      exp_fetch   = exp_pc;
      since_redir = 0;
    end
    prev_hold = s_valid & !rdy & !rv;
    prev_pc   = s_pc;
    prev_data = s_data;
    pend      = s_en & !rv;
    pend_addr = s_addr;
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release after an edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus_if.redirect_valid = 1'b0;
    #1;
    check1("rst_rom_enable", bus_if.rom_enable, 1'b0);
    check1("rst_instr_valid", bus_if.instr_valid, 1'b0);
    check("rst_rom_address", bus_if.rom_address, 32'h0000_0000);
    check("rst_instr_data", bus_if.instr_data, 32'h0000_0000);
    check("rst_instr_pc", bus_if.instr_pc, 32'h0000_0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n       = 1'b1;
    exp_pc      = 32'h0000_0000;
    exp_fetch   = 32'h0000_0000;
    pend        = 1'b0;
    prev_hold   = 1'b0;
    since_redir = 3;
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus_if.instr_ready    = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0000_0000;
    bus_if.rom_data       = 32'h0000_0000;
    pend                  = 1'b0;
    prev_hold             = 1'b0;
    exp_pc                = 32'h0000_0000;
    exp_fetch             = 32'h0000_0000;
    do_reset();

    // Streaming from reset: valid on the 3rd cycle, then one per cycle.
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check1("t1_issue", s_en, 1'b1);
      if (k < 3) begin
        check1("t1_latency", s_valid, 1'b0);
      end else begin
        check1("t1_stream", s_valid, 1'b1);
        check("t1_pc", s_pc, 32'((k - 3) * 4));
      end
    end

    // Async reset in the middle of a busy stream.
    do_reset();

    // Decode stalls: FIFO fills, issue stops, head holds pc 0.
    for (int k = 1; k <= 7; k++) cycle(1'b0, 1'b0, 32'h0);
    check1("t2_full_no_issue", s_en, 1'b0);
    check1("t2_head_valid", s_valid, 1'b1);
    check("t2_head_pc", s_pc, 32'h0000_0000);
    d0 = delivered;
    for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, 32'h0);
    check("t2_drain_count", 32'(delivered - d0), 32'd4);

    // Redirect to an unaligned target while a read is in flight.
    cycle(1'b1, 1'b1, 32'h0000_0103);
    cycle(1'b1, 1'b0, 32'h0);
    check1("t3_issue", s_en, 1'b1);
    check("t3_target_addr", s_addr, 32'h0000_0100);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check1("t3_first_valid", s_valid, 1'b1);
    check("t3_first_pc", s_pc, 32'h0000_0100);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);

    // Redirect in the same cycle as a pop.
    cycle(1'b1, 1'b1, 32'h0000_0200);
    check1("t4_valid_at_redirect", s_valid, 1'b1);
    cycle(1'b1, 1'b0, 32'h0);
    check1("t4_empty_after", s_valid, 1'b0);
    for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    wrap_seq[0] = 32'hFFFF_FFF8;
    wrap_seq[1] = 32'hFFFF_FFFC;
    wrap_seq[2] = 32'h0000_0000;
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("t5_wrap_addr", s_addr, wrap_seq[k]);
    end
    for (int k = 0; k < 3; k++) begin
      check("t5_wrap_pc", s_pc, wrap_seq[k]);
      cycle(1'b1, 1'b0, 32'h0);
    end

    // Back-to-back redirects: the later one wins.
    cycle(1'b1, 1'b1, 32'h0000_0300);
    cycle(1'b1, 1'b1, 32'h0000_0406);
    cycle(1'b1, 1'b0, 32'h0);
    check("t6_last_wins", s_addr, 32'h0000_0404);
    for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, 32'h0);

    // Randomised decode back-pressure and redirects.
    d0 = delivered;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom());
    end
    for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, 32'h0);
    check1("random_progress", (delivered - d0) >= 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Initiator side of the instruction ROM read port; owns the fetch PC.
- Issues word reads to the instruction ROM, which has a 1-cycle registered read latency and returns data in little-endian byte order.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch redirects from execute by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- rom_enable  output  1  read request to the ROM this cycle.
- rom_address  output  32  byte address of the requested word; always equals fetch_pc.
- rom_data  input  32  ROM read data; valid in the cycle after rom_enable was high.
- redirect_valid  input  1  branch/exception redirect request.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- instr_valid  output  1  FIFO head is valid.
- instr_ready  input  1  decode accepts the head entry.
- instr_data  output  32  instruction word at the FIFO head.
- instr_pc  output  32  PC of the FIFO head.

Behaviour:
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC; FIFO empty; inflight = 0; drop = 0.
  - Outputs: rom_enable = 0, rom_address = RESET_PC, instr_valid = 0, instr_data = 0, instr_pc = 0.
  - Reset mid-fetch discards the in-flight read; no entry is written.
- Definitions:
  - pop = instr_valid & instr_ready.
  - issue = !redirect_valid & (count + inflight - pop < FIFO_DEPTH).
  - rom_enable = issue (combinational).
- Issue:
  - On issue, fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 0.
  - inflight <= issue.
  - The ROM is never asked for more words than the FIFO can accept, so overflow is impossible.
- Response:
  - When inflight = 1 and drop = 0, rom_data is pushed with pc = fetch_pc - 4 at the end of the cycle.
  - When drop = 1, the response is discarded.
- Throughput and latency:
  - Sustains 1 instruction/cycle with instr_ready held high.
  - Latency from issue to instr_valid is 2 cycles: request in cycle N, data in N+1, instr_valid in N+2.
- FIFO:
  - Output is registered at the head; push and pop in the same cycle are legal, including on a full FIFO.
  - With instr_ready low, instr_valid/instr_data/instr_pc hold stable.
- Redirect (cycle R):
  - FIFO cleared; any pop or push in cycle R is discarded.
  - drop <= inflight, which kills the response arriving in R+1.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; no issue in R.
  - First issue of the target is in R+1; instr_valid is high in R+3 at the earliest.
  - Redirect outranks all other events in the same cycle.
  - Back-to-back redirects: the last one wins.
- drop clears on the cycle after it is set.

Decomposition:
- Package fetch_pkg:
  - WORD_BYTES = 4; ROM_LATENCY = 1.
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}.
  - Function align_word() that clears bits [1:0].
- Sub-module fetch_fifo (parametric depth, entries of fetch_entry_t):
  - Ports: push, pop, flush, count, head outputs.
  - Flush has priority over push and pop.
- Top level holds the PC, the issue/credit logic, and the inflight/drop flags.

Test Plan:
- Reset release, RESET_PC=0, instr_ready=1, ROM words W0..W3 at 0,4,8,12 -> rom_address 0,4,8,12 on consecutive cycles; instr_pc 0,4,8,12 with matching data from the 3rd cycle after reset, 1 per cycle, no bubbles.
- instr_ready=0 for 5 cycles after the first valid -> rom_enable drops after the FIFO fills (count=2, inflight=0); head stays pc=0; on release, pcs 0,4,8 are delivered in order with no loss or duplicate.
- redirect_valid with redirect_pc=32'h0000_0103 while a read is in flight and the FIFO holds 2 entries -> next rom_address=32'h100; the stale response is dropped; the first instr_pc after the redirect is 32'h100.
- Redirect in the same cycle as a pop with instr_ready=1 -> FIFO empty the next cycle; no entry from the old stream appears afterwards.
- fetch_pc at 32'hFFFF_FFF8 -> rom_address sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc follows the same sequence.
- rst_n asserted asynchronously mid-cycle with inflight=1 and a full FIFO -> instr_valid and rom_enable drop immediately; after release, fetch restarts at RESET_PC with no stale entry.
